rice_core_id_queue_stage: RTL and testbench
===========================================

Name: rice_core_id_queue_stage

Overview:
- Parametrised successor decode stage. A DEPTH-entry instruction queue decouples fetch from decode, so fetch keeps running while execute stalls.
- Holds raw fetched instructions (pc, inst) in a circular queue. Decodes the head entry into a registered result with a valid/ready handshake toward execute.
- Register-file operands are read when an entry moves into the output register, never when it enters the queue, so a queued entry cannot carry stale operands.
- Sits between the IF stage and the EX stage of the rice core.

Parameters:
- XLEN, 32, data/address width; 32 or 64.
- DEPTH, 4, queue entries; power of two, >= 2.
- BYPASS, 1, 1 = an empty queue forwards the input straight into the output register (1-cycle latency); 0 = every instruction passes through the queue (2-cycle latency).

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_enable  input  1  0 forces output invalid and drops arrivals; queue contents kept
- i_flush  input  1  discard queue and output register
- i_if_valid  input  1  fetch offers an instruction
- o_if_ready  output  1  queue can accept (count < DEPTH)
- i_if_pc  input  XLEN  fetched pc
- i_if_inst  input  32  fetched instruction
- i_register_file  input  32*XLEN  architectural registers, packed [31:0]
- o_id_valid  output  1  decoded result valid
- i_id_ready  input  1  execute accepts result
- o_id_pc  output  XLEN  pc of result
- o_id_inst  output  32  raw instruction
- o_id_rs1, o_id_rs2, o_id_rd  output  5 each  decoded indices; zero where the format has no such field
- o_id_rs1_value, o_id_rs2_value  output  XLEN each  register values
- o_id_imm_value  output  XLEN  sign-extended immediate per I/S/B/U/J format
- o_id_count  output  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Clock and reset: one clock, i_clk. i_rst_n is asynchronous, active-low.
- Reset: write/read pointers = 0, count = 0, o_id_valid = 0, all o_id_* data = 0, o_if_ready = 1.
- Enqueue when i_if_valid && o_if_ready && i_enable && !i_flush. Pointers wrap modulo DEPTH.
- Output register loads when (!o_id_valid || i_id_ready) && source available, where source = queue head if count > 0, else the input if BYPASS and the input is enqueuing.
- A bypassed instruction does not occupy the queue.
- On load: decode fields from the source instruction; sample rs1/rs2 values from i_register_file in the same cycle; index 0 reads 0.
- o_id_valid holds with stable data while i_id_ready = 0. A transfer occurs on the cycle where o_id_valid && i_id_ready.
- Ordering: the queue head always has priority over the input, so program order is strictly preserved.
- Simultaneous enqueue and dequeue at count == DEPTH: not possible, because o_if_ready = 0. At count == DEPTH-1 with both enqueue and dequeue, count stays DEPTH-1.
- Full: o_if_ready = 0 combinationally from count; no overwrite.
- Empty with BYPASS = 0: the output register waits one cycle after the enqueue.
- i_flush: next cycle count = 0, pointers = 0, o_id_valid = 0. Input is ignored in the flush cycle. Flush dominates i_enable and the handshakes.
- i_enable = 0: o_id_valid forced 0 next cycle; the queue neither enqueues nor dequeues.
- Reset mid-operation: everything returns to reset values immediately (asynchronous).
- Immediate rules:
  - I: sign-extend inst[31:20].
  - S: {inst[31:25], inst[11:7]}, sign-extended.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
  - U: {inst[31:12], 12'b0}, sign-extended to XLEN.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.

Optional Feature:
- Macro: RICE_CORE_ID_QUEUE_ILLEGAL_CHECK_EN.
- Defined:
  - Adds output o_id_illegal (1 bit), registered with the result.
  - o_id_illegal = 1 when inst[1:0] != 2'b11, or the opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
  - For an illegal instruction, rs1/rs2/rd outputs are forced to 0.
  - Reset value 0.
- Undefined: the port is absent and no check is made.

Test Plan:
- Reset, then addi x1,x2,-1 (0xFFF10093) at pc 0x100 with BYPASS=1 and x2=5 -> next cycle o_id_valid=1, rs1=2, rd=1, rs2=0, imm=0xFFFFFFFF, rs1_value=5.
- i_id_ready=0 with 4 consecutive fetches at DEPTH=4 -> first in output register, next three queued; the fifth offer sees o_if_ready=1 then 0 once count=4. Release i_id_ready -> outputs drain in pc order 0x100, 0x104, ... with no loss.
- Queue full (count=4) and i_id_ready=1 with i_if_valid=1 for 8 cycles -> one transfer per cycle, count stays between 3 and 4, order preserved.
- i_flush while count=3 and o_id_valid=1 -> next cycle count=0, o_id_valid=0, o_if_ready=1; the instruction offered during the flush cycle is never output.
- Write x3=0x55 while `sw x3,8(x4)` (0x00322423) waits in the queue -> on output rs2_value=0x55, rd=0, imm=8.
- With RICE_CORE_ID_QUEUE_ILLEGAL_CHECK_EN defined, inst 0x00000000 -> o_id_illegal=1 and rs1=rs2=rd=0. Then inst 0x00000013 -> o_id_illegal=0.

Source files
------------

// File: rtl/rice_core_id_queue_stage.sv
// rtl/rice_core_id_queue_stage.sv - decode stage behind a DEPTH-entry instruction queue
// Optional RICE_CORE_ID_QUEUE_ILLEGAL_CHECK_EN adds the registered o_id_illegal flag.
module rice_core_id_queue_stage #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic                      i_flush,
    input  logic                      i_if_valid,
    output logic                      o_if_ready,
    input  logic [XLEN-1:0]           i_if_pc,
    input  logic [31:0]               i_if_inst,
    input  logic [32*XLEN-1:0]        i_register_file,
    output logic                      o_id_valid,
    input  logic                      i_id_ready,
    output logic [XLEN-1:0]           o_id_pc,
    output logic [31:0]               o_id_inst,
    output logic [4:0]                o_id_rs1,
    output logic [4:0]                o_id_rs2,
    output logic [4:0]                o_id_rd,
    output logic [XLEN-1:0]           o_id_rs1_value,
    output logic [XLEN-1:0]           o_id_rs2_value,
    output logic [XLEN-1:0]           o_id_imm_value,
    output logic [$clog2(DEPTH):0]    o_id_count
`ifdef RICE_CORE_ID_QUEUE_ILLEGAL_CHECK_EN
    ,
    output logic                      o_id_illegal
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [31:0]     r_q_inst [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            r_id_valid;
    logic [XLEN-1:0] r_id_pc;
    logic [31:0]     r_id_inst;
    logic [4:0]      r_id_rs1, r_id_rs2, r_id_rd;
    logic [XLEN-1:0] r_id_rs1_value, r_id_rs2_value, r_id_imm_value;

    logic            w_enq, w_load, w_deq, w_push, w_from_queue;
    logic [XLEN-1:0] w_src_pc;
    logic [31:0]     w_src_inst;
    logic            w_known, w_use_rs1, w_use_rs2, w_use_rd;
    logic [31:0]     w_imm32;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_regs [32];

    assign o_if_ready   = (r_count < DEPTH_C);
    assign o_id_count   = r_count;
    assign w_from_queue = (r_count != '0);
    assign w_enq  = i_if_valid && o_if_ready && i_enable && !i_flush;
    // Queue head always wins over the input so program order is kept.
    assign w_load = i_enable && !i_flush && (!r_id_valid || i_id_ready)
                    && (w_from_queue || (BYPASS && w_enq));
    assign w_deq  = w_load && w_from_queue;
    assign w_push = w_enq && !(w_load && !w_from_queue);

    assign w_src_pc   = w_from_queue ? r_q_pc[r_rd_ptr]   : i_if_pc;
    assign w_src_inst = w_from_queue ? r_q_inst[r_rd_ptr] : i_if_inst;

    always_comb begin
        w_known   = 1'b1;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_imm32   = '0;
        case (w_src_inst[6:0])
            7'b0110111, 7'b0010111: begin
                w_use_rd = 1'b1;
                w_imm32  = {w_src_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                w_use_rd = 1'b1;
                w_imm32  = {{11{w_src_inst[31]}}, w_src_inst[31], w_src_inst[19:12],
                            w_src_inst[20], w_src_inst[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_imm32   = {{20{w_src_inst[31]}}, w_src_inst[31:20]};
            end
            7'b1100011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm32   = {{19{w_src_inst[31]}}, w_src_inst[31], w_src_inst[7],
                             w_src_inst[30:25], w_src_inst[11:8], 1'b0};
            end
            7'b0100011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm32   = {{20{w_src_inst[31]}}, w_src_inst[31:25], w_src_inst[11:7]};
            end
            7'b0110011: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    assign w_rs1 = w_use_rs1 ? w_src_inst[19:15] : 5'd0;
    assign w_rs2 = w_use_rs2 ? w_src_inst[24:20] : 5'd0;
    assign w_rd  = w_use_rd  ? w_src_inst[11:7]  : 5'd0;

    for (genvar g = 0; g < 32; g++) begin : g_regs
        assign w_regs[g] = i_register_file[g*XLEN +: XLEN];
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= i_if_pc;
            r_q_inst[r_wr_ptr] <= i_if_inst;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Operands are sampled here, at load time, so queued entries never go stale.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id_valid     <= 1'b0;
            r_id_pc        <= '0;
            r_id_inst      <= '0;
            r_id_rs1       <= '0;
            r_id_rs2       <= '0;
            r_id_rd        <= '0;
            r_id_rs1_value <= '0;
            r_id_rs2_value <= '0;
            r_id_imm_value <= '0;
`ifdef RICE_CORE_ID_QUEUE_ILLEGAL_CHECK_EN
            o_id_illegal   <= 1'b0;
`endif
        end else if (i_flush || !i_enable) begin
            r_id_valid <= 1'b0;
        end else if (w_load) begin
            r_id_valid     <= 1'b1;
            r_id_pc        <= w_src_pc;
            r_id_inst      <= w_src_inst;
            r_id_rs1       <= w_rs1;
            r_id_rs2       <= w_rs2;
            r_id_rd        <= w_rd;
            r_id_rs1_value <= (w_rs1 == 5'd0) ? '0 : w_regs[w_rs1];
            r_id_rs2_value <= (w_rs2 == 5'd0) ? '0 : w_regs[w_rs2];
            r_id_imm_value <= XLEN'($signed(w_imm32));
`ifdef RICE_CORE_ID_QUEUE_ILLEGAL_CHECK_EN
            o_id_illegal   <= !w_known;
`endif
        end else if (i_id_ready) begin
            r_id_valid <= 1'b0;
        end
    end

    assign o_id_valid     = r_id_valid;
    assign o_id_pc        = r_id_pc;
    assign o_id_inst      = r_id_inst;
    assign o_id_rs1       = r_id_rs1;
    assign o_id_rs2       = r_id_rs2;
    assign o_id_rd        = r_id_rd;
    assign o_id_rs1_value = r_id_rs1_value;
    assign o_id_rs2_value = r_id_rs2_value;
    assign o_id_imm_value = r_id_imm_value;
endmodule

// File: tb/tb_rice_core_id_queue_stage.sv
// tb/tb_rice_core_id_queue_stage.sv - scoreboard bench for rice_core_id_queue_stage
module tb_rice_core_id_queue_stage;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   i_enable, i_flush, i_if_valid, i_id_ready;
    logic                   o_if_ready, o_id_valid;
    logic [XLEN-1:0]        i_if_pc;
    logic [31:0]            i_if_inst;
    logic [32*XLEN-1:0]     rf;
    logic [XLEN-1:0]        o_id_pc, o_id_rs1_value, o_id_rs2_value, o_id_imm_value;
    logic [31:0]            o_id_inst;
    logic [4:0]             o_id_rs1, o_id_rs2, o_id_rd;
    logic [$clog2(DEPTH):0] o_id_count;
`ifdef RICE_CORE_ID_QUEUE_ILLEGAL_CHECK_EN
    logic                   o_id_illegal;
`endif

    exp_t sb[$];
    exp_t tbl[10];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rice_core_id_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .BYPASS(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(i_enable), .i_flush(i_flush),
        .i_if_valid(i_if_valid), .o_if_ready(o_if_ready), .i_if_pc(i_if_pc),
        .i_if_inst(i_if_inst), .i_register_file(rf), .o_id_valid(o_id_valid),
        .i_id_ready(i_id_ready), .o_id_pc(o_id_pc), .o_id_inst(o_id_inst),
        .o_id_rs1(o_id_rs1), .o_id_rs2(o_id_rs2), .o_id_rd(o_id_rd),
        .o_id_rs1_value(o_id_rs1_value), .o_id_rs2_value(o_id_rs2_value),
        .o_id_imm_value(o_id_imm_value), .o_id_count(o_id_count)
`ifdef RICE_CORE_ID_QUEUE_ILLEGAL_CHECK_EN
        , .o_id_illegal(o_id_illegal)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic set_reg(input int r, input logic [31:0] v);
        rf[r*32 +: 32] = v;
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input int k);
        exp_t e;
        e    = tbl[k];
        e.pc = pc;
        return e;
    endfunction

    task automatic monitor();
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (rst_n && o_id_valid && i_id_ready) begin
                a.pc = o_id_pc;   a.inst = o_id_inst;
                a.rs1 = o_id_rs1; a.rs2 = o_id_rs2; a.rd = o_id_rd;
                a.rs1v = o_id_rs1_value; a.rs2v = o_id_rs2_value; a.imm = o_id_imm_value;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: pc %h with nothing pending", o_id_pc);
                end else begin
                    e = sb.pop_front();
`ifdef RICE_CORE_ID_QUEUE_ILLEGAL_CHECK_EN
                    a.ill = o_id_illegal;
`else
                    a.ill = e.ill;
`endif
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL transfer: got pc=%h inst=%h rs=%0d/%0d/%0d val=%h/%h imm=%h ill=%b, expected pc=%h inst=%h rs=%0d/%0d/%0d val=%h/%h imm=%h ill=%b",
                                 a.pc, a.inst, a.rs1, a.rs2, a.rd, a.rs1v, a.rs2v, a.imm, a.ill,
                                 e.pc, e.inst, e.rs1, e.rs2, e.rd, e.rs1v, e.rs2v, e.imm, e.ill);
                    end
                end
            end
        end
    endtask

    task automatic offer(input exp_t e);
        bit done;
        done       = 1'b0;
        i_if_valid = 1'b1;
        i_if_pc    = e.pc;
        i_if_inst  = e.inst;
        for (int c = 0; c < 50 && !done; c++) begin
            if (o_if_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        i_if_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL offer_timeout: pc %h never accepted", e.pc);
        end
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while ((o_id_count != 0 || o_id_valid) && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        check(name, {63'd0, (o_id_count == 0 && !o_id_valid)}, 64'd1);
    endtask

    initial begin
        exp_t e;
        //           pc  inst          rs1 rs2 rd  rs1v         rs2v         imm          ill
        tbl[0] = '{0, 32'hFFF10093, 2, 0, 1,  32'h5,       32'h0,       32'hFFFFFFFF, 0};
        tbl[1] = '{0, 32'h123452B7, 0, 0, 5,  32'h0,       32'h0,       32'h12345000, 0};
        tbl[2] = '{0, 32'hFE208EE3, 1, 2, 0,  32'h11,      32'h5,       32'hFFFFFFFC, 0};
        tbl[3] = '{0, 32'h008000EF, 0, 0, 1,  32'h0,       32'h0,       32'h8,        0};
        tbl[4] = '{0, 32'h006283B3, 5, 6, 7,  32'h1234,    32'h66,      32'h0,        0};
        tbl[5] = '{0, 32'hFFFFF517, 0, 0, 10, 32'h0,       32'h0,       32'hFFFFF000, 0};
        tbl[6] = '{0, 32'hFF84A403, 9, 0, 8,  32'h99,      32'h0,       32'hFFFFFFF8, 0};
        tbl[7] = '{0, 32'h00322423, 4, 3, 0,  32'h44,      32'h33,      32'h8,        0};
        tbl[8] = '{0, 32'h00000013, 0, 0, 0,  32'h0,       32'h0,       32'h0,        0};
        tbl[9] = '{0, 32'h00000000, 0, 0, 0,  32'h0,       32'h0,       32'h0,        1};

        rf = '0;
        set_reg(0, 32'hDEAD);
        set_reg(1, 32'h11); set_reg(2, 32'h5);    set_reg(3, 32'h33); set_reg(4, 32'h44);
        set_reg(5, 32'h1234); set_reg(6, 32'h66); set_reg(9, 32'h99);
        rst_n = 1'b0; i_enable = 1'b1; i_flush = 1'b0; i_if_valid = 1'b0;
        i_id_ready = 1'b0; i_if_pc = '0; i_if_inst = '0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {63'd0, o_id_valid}, 64'd0);
        check("reset_ready", {63'd0, o_if_ready}, 64'd1);
        check("reset_count", {61'd0, o_id_count}, 64'd0);
        check("reset_pc_inst", {o_id_pc, o_id_inst}, 64'd0);
        check("reset_imm_vals", {o_id_imm_value, o_id_rs1_value}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single bypassed addi
        offer(mk(32'h100, 0));
        check("bypass_valid", {63'd0, o_id_valid}, 64'd1);
        check("bypass_count", {61'd0, o_id_count}, 64'd0);
        check("bypass_rs1_value", {32'd0, o_id_rs1_value}, 64'h5);
        i_id_ready = 1'b1;
        @(posedge clk); #1;
        i_id_ready = 1'b0;
        check("after_transfer_valid", {63'd0, o_id_valid}, 64'd0);

        // fill behind a stalled execute
        for (int i = 0; i < 4; i++) offer(mk(32'h100 + 32'(4*i), i));
        check("fill_count3", {61'd0, o_id_count}, 64'd3);
        check("fill_valid", {63'd0, o_id_valid}, 64'd1);
        offer(mk(32'h110, 4));
        check("full_count", {61'd0, o_id_count}, 64'd4);
        check("full_ready", {63'd0, o_if_ready}, 64'd0);
        i_if_valid = 1'b1; i_if_pc = 32'h114; i_if_inst = tbl[5].inst;
        repeat (2) begin
            @(posedge clk); #1;
            check("full_hold_count", {61'd0, o_id_count}, 64'd4);
            check("full_hold_ready", {63'd0, o_if_ready}, 64'd0);
        end
        check("stall_pc_stable", {32'd0, o_id_pc}, 64'h100);
        i_id_ready = 1'b1;
        offer(mk(32'h114, 5));
        check("release_count", {61'd0, o_id_count}, 64'd3);
        for (int i = 0; i < 8; i++) begin
            offer(mk(32'h118 + 32'(4*i), i));
            check("stream_count_3_4", {63'd0, (o_id_count == 3 || o_id_count == 4)}, 64'd1);
        end
        drain("drain_stream");
        i_id_ready = 1'b0;

        // flush with a populated queue
        for (int i = 0; i < 4; i++) offer(mk(32'h400 + 32'(4*i), i));
        check("preflush_count", {61'd0, o_id_count}, 64'd3);
        check("preflush_valid", {63'd0, o_id_valid}, 64'd1);
        i_flush = 1'b1; i_if_valid = 1'b1; i_if_pc = 32'h900; i_if_inst = tbl[0].inst;
        @(posedge clk); #1;
        i_flush = 1'b0; i_if_valid = 1'b0;
        sb.delete();
        check("flush_count", {61'd0, o_id_count}, 64'd0);
        check("flush_valid", {63'd0, o_id_valid}, 64'd0);
        check("flush_ready", {63'd0, o_if_ready}, 64'd1);
        i_id_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_leak", {63'd0, o_id_valid}, 64'd0);
        i_id_ready = 1'b0;

        // enable low drops the output and the arrival, keeps the queue
        offer(mk(32'h500, 1));
        offer(mk(32'h504, 2));
        i_enable = 1'b0; i_if_valid = 1'b1; i_if_pc = 32'h508; i_if_inst = tbl[3].inst;
        @(posedge clk); #1;
        i_if_valid = 1'b0;
        check("disable_valid", {63'd0, o_id_valid}, 64'd0);
        check("disable_count", {61'd0, o_id_count}, 64'd1);
        sb.delete(0);
        i_enable = 1'b1; i_id_ready = 1'b1;
        drain("drain_disable");
        i_id_ready = 1'b0;

        // operand read at load time, not at enqueue time
        offer(mk(32'h600, 0));
        e = mk(32'h604, 7);
        e.rs2v = 32'h55;
        offer(e);
        check("stale_queued", {61'd0, o_id_count}, 64'd1);
        set_reg(3, 32'h55);
        i_id_ready = 1'b1;
        drain("drain_stale");

        // all-zero word (illegal) then canonical nop
        offer(mk(32'h700, 9));
        offer(mk(32'h704, 8));
        drain("drain_illegal");

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
